// File: rtl/route_compute_xy.sv
// Registered XY dimension-order route computation for one router input port.
// Latches the route per packet and flags flit-sequence and out-of-mesh errors.
module route_compute_xy #(
    parameter int FLIT_WIDTH = 8,
    parameter int X_NODE_NUM = 4,
    parameter int Y_NODE_NUM = 4,
    parameter int X_ADDR     = 0,
    parameter int Y_ADDR     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_port,
    output logic [4:0]            out_onehot,
    output logic                  busy,
    output logic                  proto_err,
    output logic                  dest_err
);

    localparam int XW = ($clog2(X_NODE_NUM) > 1) ? $clog2(X_NODE_NUM) : 1;
    localparam int YW = ($clog2(Y_NODE_NUM) > 1) ? $clog2(Y_NODE_NUM) : 1;

    localparam logic signed [XW:0] X_LOC = (XW+1)'(X_ADDR);
    localparam logic signed [YW:0] Y_LOC = (YW+1)'(Y_ADDR);
    localparam logic [XW:0]        X_LIM = (XW+1)'(X_NODE_NUM);
    localparam logic [YW:0]        Y_LIM = (YW+1)'(Y_NODE_NUM);

    localparam logic [3:0] PORT_NONE = 4'd0;
    localparam logic [3:0] PORT_L    = 4'd1;
    localparam logic [3:0] PORT_E    = 4'd2;
    localparam logic [3:0] PORT_N    = 4'd3;
    localparam logic [3:0] PORT_W    = 4'd4;
    localparam logic [3:0] PORT_S    = 4'd5;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b01;
    localparam logic [1:0] FT_HEAD   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    // Returns {dest_err, port}; an out-of-mesh destination is delivered locally.
    function automatic logic [4:0] calc_route(input logic [XW-1:0] xd, input logic [YW-1:0] yd);
        logic signed [XW:0] xdiff;
        logic signed [YW:0] ydiff;
        logic               err;
        logic [3:0]         port;
        xdiff = $signed({1'b0, xd}) - X_LOC;
        ydiff = $signed({1'b0, yd}) - Y_LOC;
        err   = ({1'b0, xd} >= X_LIM) || ({1'b0, yd} >= Y_LIM);
        if (err) begin
            port = PORT_L;
        end else if (xdiff != '0) begin
            port = xdiff[XW] ? PORT_W : PORT_E;
        end else if (ydiff != '0) begin
            port = ydiff[YW] ? PORT_N : PORT_S;
        end else begin
            port = PORT_L;
        end
        return {err, port};
    endfunction

    function automatic logic [4:0] port_onehot(input logic [3:0] port);
        logic [4:0] oh;
        case (port)
            PORT_L:  oh = 5'b00001;
            PORT_E:  oh = 5'b00010;
            PORT_W:  oh = 5'b00100;
            PORT_S:  oh = 5'b01000;
            PORT_N:  oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              route_q, route_d;
    logic [FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;
    logic                    out_valid_q, out_valid_d;
    logic [3:0]              out_port_q, out_port_d;
    logic [4:0]              out_onehot_q, out_onehot_d;
    logic                    busy_q, busy_d;
    logic                    proto_err_q, proto_err_d;
    logic                    dest_err_q, dest_err_d;

    logic [1:0]              flit_type_s;
    logic [4:0]              route_calc_s;
    logic                    accept_s;

    assign in_ready     = !out_valid_q || out_ready;
    assign accept_s     = in_valid && in_ready;
    assign flit_type_s  = in_flit[FLIT_WIDTH-1 -: 2];
    assign route_calc_s = calc_route(in_flit[YW +: XW], in_flit[0 +: YW]);

    // Next-state and output-register computation for packet tracking.
    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;
        out_port_d  = out_port_q;
        proto_err_d = proto_err_q;
        dest_err_d  = dest_err_q;
        if (accept_s) begin
            out_flit_d  = in_flit;
            out_valid_d = 1'b1;
            proto_err_d = 1'b0;
            dest_err_d  = 1'b0;
            case (flit_type_s)
                FT_HEAD: begin
                    proto_err_d = (state_q == ST_PKT);
                    dest_err_d  = route_calc_s[4];
                    route_d     = route_calc_s[3:0];
                    out_port_d  = route_calc_s[3:0];
                    state_d     = ST_PKT;
                end
                FT_SINGLE: begin
                    proto_err_d = (state_q == ST_PKT);
                    dest_err_d  = route_calc_s[4];
                    out_port_d  = route_calc_s[3:0];
                    state_d     = ST_IDLE;
                end
                FT_BODY, FT_TAIL: begin
                    if (state_q == ST_PKT) begin
                        out_port_d = route_q;
                        state_d    = (flit_type_s == FT_TAIL) ? ST_IDLE : ST_PKT;
                    end else begin
                        out_port_d  = PORT_NONE;
                        proto_err_d = 1'b1;
                    end
                end
                default: begin
                    out_port_d  = PORT_NONE;
                    proto_err_d = 1'b1;
                end
            endcase
        end else if (out_ready) begin
            // Output drained with nothing new: drop valid and close the error pulses.
            out_valid_d = 1'b0;
            proto_err_d = 1'b0;
            dest_err_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Decoded views registered alongside the port code.
    always_comb begin
        out_onehot_d = port_onehot(out_port_d);
        busy_d       = (state_d == ST_PKT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            route_q      <= 4'd0;
            out_flit_q   <= '0;
            out_valid_q  <= 1'b0;
            out_port_q   <= 4'd0;
            out_onehot_q <= 5'd0;
            busy_q       <= 1'b0;
            proto_err_q  <= 1'b0;
            dest_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            route_q      <= route_d;
            out_flit_q   <= out_flit_d;
            out_valid_q  <= out_valid_d;
            out_port_q   <= out_port_d;
            out_onehot_q <= out_onehot_d;
            busy_q       <= busy_d;
            proto_err_q  <= proto_err_d;
            dest_err_q   <= dest_err_d;
        end
    end

    assign out_flit   = out_flit_q;
    assign out_valid  = out_valid_q;
    assign out_port   = out_port_q;
    assign out_onehot = out_onehot_q;
    assign busy       = busy_q;
    assign proto_err  = proto_err_q;
    assign dest_err   = dest_err_q;

endmodule

// File: tb/tb_route_compute_xy.sv
// Bench for route_compute_xy: two parameterisations driven with shared stimulus,
// compared every cycle against a behavioural model plus directed literal checks.
module tb_route_compute_xy;

    localparam int XN [2] = '{4, 3};
    localparam int YN [2] = '{4, 4};
    localparam int XA [2] = '{0, 2};
    localparam int YA [2] = '{1, 1};
    localparam int BITPOS [6] = '{0, 0, 1, 4, 2, 3};

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_flit;

    logic       in_ready [2];
    logic [7:0] o_flit   [2];
    logic       o_valid  [2];
    logic [3:0] o_port   [2];
    logic [4:0] o_oh     [2];
    logic       o_busy   [2];
    logic       o_perr   [2];
    logic       o_derr   [2];

    int nchecks = 0;
    int nerr    = 0;

    bit         m_valid [2];
    logic [7:0] m_flit  [2];
    int         m_port  [2];
    bit         m_perr  [2];
    bit         m_derr  [2];
    bit         m_open  [2];
    int         m_route [2];

    always #5 clk = ~clk;

    route_compute_xy #(.FLIT_WIDTH(8), .X_NODE_NUM(4), .Y_NODE_NUM(4), .X_ADDR(0), .Y_ADDR(1)) dut_a (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready[0]),
        .out_flit(o_flit[0]), .out_valid(o_valid[0]), .out_ready(out_ready), .out_port(o_port[0]),
        .out_onehot(o_oh[0]), .busy(o_busy[0]), .proto_err(o_perr[0]), .dest_err(o_derr[0])
    );

    route_compute_xy #(.FLIT_WIDTH(8), .X_NODE_NUM(3), .Y_NODE_NUM(4), .X_ADDR(2), .Y_ADDR(1)) dut_b (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready[1]),
        .out_flit(o_flit[1]), .out_valid(o_valid[1]), .out_ready(out_ready), .out_port(o_port[1]),
        .out_onehot(o_oh[1]), .busy(o_busy[1]), .proto_err(o_perr[1]), .dest_err(o_derr[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    function automatic void route_of(input int k, input logic [7:0] f, output int port, output bit derr);
        int xd;
        int yd;
        xd = int'(f[3:2]);
        yd = int'(f[1:0]);
        derr = (xd >= XN[k]) || (yd >= YN[k]);
        if (derr)            port = 1;
        else if (xd > XA[k]) port = 2;
        else if (xd < XA[k]) port = 4;
        else if (yd > YA[k]) port = 5;
        else if (yd < YA[k]) port = 3;
        else                 port = 1;
    endfunction

    function automatic int onehot_of(input int port);
        return (port == 0) ? 0 : (1 << BITPOS[port]);
    endfunction

    // Behavioural model of both instances, advanced on each rising edge.
    always @(posedge clk) begin : model
        int         p;
        bit         de;
        bit         acc;
        logic [1:0] ty;
        for (int k = 0; k < 2; k++) begin
            acc = in_valid && (!m_valid[k] || out_ready);
            ty  = in_flit[7:6];
            route_of(k, in_flit, p, de);
            if (rst) begin
                m_valid[k] <= 1'b0; m_flit[k] <= 8'h00; m_port[k] <= 0;
                m_perr[k]  <= 1'b0; m_derr[k] <= 1'b0;  m_open[k] <= 1'b0; m_route[k] <= 0;
            end else if (acc) begin
                m_valid[k] <= 1'b1;
                m_flit[k]  <= in_flit;
                if (ty == 2'b10) begin
                    m_perr[k] <= m_open[k]; m_derr[k] <= de; m_open[k] <= 1'b1;
                    m_route[k] <= p; m_port[k] <= p;
                end else if (ty == 2'b11) begin
                    m_perr[k] <= m_open[k]; m_derr[k] <= de; m_open[k] <= 1'b0; m_port[k] <= p;
                end else begin
                    m_derr[k] <= 1'b0;
                    if (m_open[k]) begin
                        m_perr[k] <= 1'b0; m_port[k] <= m_route[k];
                        if (ty == 2'b01) m_open[k] <= 1'b0;
                    end else begin
                        m_perr[k] <= 1'b1; m_port[k] <= 0;
                    end
                end
            end else if (out_ready) begin
                m_valid[k] <= 1'b0; m_perr[k] <= 1'b0; m_derr[k] <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, 32'(o_valid[k]), 32'(m_valid[k]));
            chk("busy",      k, 32'(o_busy[k]),  32'(m_open[k]));
            chk("proto_err", k, 32'(o_perr[k]),  32'(m_perr[k]));
            chk("dest_err",  k, 32'(o_derr[k]),  32'(m_derr[k]));
            chk("in_ready",  k, 32'(in_ready[k]), 32'(!m_valid[k] || out_ready));
            if (m_valid[k]) begin
                chk("out_flit",   k, 32'(o_flit[k]), 32'(m_flit[k]));
                chk("out_port",   k, 32'(o_port[k]), m_port[k]);
                chk("out_onehot", k, 32'(o_oh[k]),   onehot_of(m_port[k]));
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] f, input bit r);
        in_valid  = v;
        in_flit   = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_flit = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, 32'(o_valid[0]), 32'd0);
        chk("rst_flit",  0, 32'(o_flit[0]),  32'd0);
        chk("rst_port",  0, 32'(o_port[0]),  32'd0);
        chk("rst_oh",    0, 32'(o_oh[0]),    32'd0);
        chk("rst_busy",  0, 32'(o_busy[0]),  32'd0);
        rst = 1'b0;

        cyc(1'b1, 8'hC1, 1'b1);
        chk("single_port", 0, 32'(o_port[0]), 32'd1);
        chk("single_oh",   0, 32'(o_oh[0]),   32'h01);
        chk("single_busy", 0, 32'(o_busy[0]), 32'd0);

        cyc(1'b1, 8'h8B, 1'b1);
        chk("hdr_port", 0, 32'(o_port[0]), 32'd2);
        chk("hdr_oh",   0, 32'(o_oh[0]),   32'h02);
        chk("hdr_busy", 0, 32'(o_busy[0]), 32'd1);
        cyc(1'b1, 8'h00, 1'b1);
        chk("body_port", 0, 32'(o_port[0]), 32'd2);
        cyc(1'b1, 8'h40, 1'b1);
        chk("tail_port", 0, 32'(o_port[0]), 32'd2);
        chk("tail_oh",   0, 32'(o_oh[0]),   32'h02);
        chk("tail_busy", 0, 32'(o_busy[0]), 32'd0);

        cyc(1'b1, 8'hC0, 1'b1);
        chk("north_port", 0, 32'(o_port[0]), 32'd3);
        chk("north_oh",   0, 32'(o_oh[0]),   32'h10);
        cyc(1'b1, 8'hC3, 1'b1);
        chk("south_port", 0, 32'(o_port[0]), 32'd5);
        chk("south_oh",   0, 32'(o_oh[0]),   32'h08);
        cyc(1'b1, 8'hC4, 1'b1);
        chk("west_port", 1, 32'(o_port[1]), 32'd4);
        chk("west_oh",   1, 32'(o_oh[1]),   32'h04);
        cyc(1'b1, 8'hCC, 1'b1);
        chk("range_port", 1, 32'(o_port[1]), 32'd1);
        chk("range_derr", 1, 32'(o_derr[1]), 32'd1);
        chk("inrange_derr", 0, 32'(o_derr[0]), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("derr_pulse_end", 1, 32'(o_derr[1]), 32'd0);

        cyc(1'b1, 8'hC3, 1'b0);
        chk("bp_first", 0, 32'(o_flit[0]), 32'hC3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'hC0, 1'b0);
            chk("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
            chk("bp_hold_flit", 0, 32'(o_flit[0]), 32'hC3);
            chk("bp_hold_port", 0, 32'(o_port[0]), 32'd5);
        end
        cyc(1'b1, 8'hC0, 1'b1);
        chk("bp_release_flit", 0, 32'(o_flit[0]), 32'hC0);
        chk("bp_release_port", 0, 32'(o_port[0]), 32'd3);

        cyc(1'b1, 8'h00, 1'b1);
        chk("orphan_port", 0, 32'(o_port[0]), 32'd0);
        chk("orphan_oh",   0, 32'(o_oh[0]),   32'd0);
        chk("orphan_perr", 0, 32'(o_perr[0]), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("orphan_perr_end", 0, 32'(o_perr[0]), 32'd0);

        cyc(1'b1, 8'h8B, 1'b1);
        cyc(1'b1, 8'h80, 1'b1);
        chk("rehdr_perr", 0, 32'(o_perr[0]), 32'd1);
        chk("rehdr_port", 0, 32'(o_port[0]), 32'd3);
        chk("rehdr_busy", 0, 32'(o_busy[0]), 32'd1);
        cyc(1'b1, 8'h40, 1'b1);
        chk("rehdr_tail_port", 0, 32'(o_port[0]), 32'd3);
        chk("rehdr_tail_busy", 0, 32'(o_busy[0]), 32'd0);

        cyc(1'b1, 8'h8B, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        chk("midrst_valid", 0, 32'(o_valid[0]), 32'd0);
        chk("midrst_flit",  0, 32'(o_flit[0]),  32'd0);
        chk("midrst_port",  0, 32'(o_port[0]),  32'd0);
        chk("midrst_busy",  0, 32'(o_busy[0]),  32'd0);
        chk("midrst_perr",  0, 32'(o_perr[0]),  32'd0);
        rst = 1'b0;
        cyc(1'b1, 8'h00, 1'b1);
        chk("postrst_perr", 0, 32'(o_perr[0]), 32'd1);
        chk("postrst_port", 0, 32'(o_port[0]), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        repeat (3) cyc(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
